turbo_intlv_addr_seq: RTL and testbench

- Read-side sequencer in the HPGP turbo interleaver RX path. Sits directly upstream of the preloaded permutation-table RAM and drives that RAM's read port.
- On start, walks natural indices 0..len-1 from a base offset and reads one table entry per index. The RAM has 1-cycle read latency and holds rdata while ren is low.
- Streams each (natural index, interleaved address) pair downstream over a valid/ready handshake, at full throughput when not back-pressured.

---
 rtl/turbo_intlv_pkg.sv | 24 ++
 rtl/turbo_intlv_addr_seq_if.sv | 30 +++
 rtl/turbo_intlv_addr_seq.sv | 95 +++++++++
 tb/tb_turbo_intlv_addr_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/turbo_intlv_pkg.sv
// Shared definitions for the turbo interleaver RX address path.
// Holds the sequencer state encoding, default widths and the HPGP block table layout.
package turbo_intlv_pkg;

    localparam int A_WIDTH_DEF = 13;
    localparam int D_WIDTH_DEF = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // HPGP block lengths in table entries
    localparam int PB16_LEN  = 128;
    localparam int PB136_LEN = 1088;
    localparam int PB520_LEN = 4160;

    // Permutation tables are packed back to back in the RAM
    localparam int PB16_BASE  = 0;
    localparam int PB136_BASE = PB16_BASE + PB16_LEN;
    localparam int PB520_BASE = PB136_BASE + PB136_LEN;

endpackage

// File: rtl/turbo_intlv_addr_seq_if.sv
// Downstream stream of (natural index, interleaved address) pairs.
// The master drives the pair and valid; the slave returns ready.
interface turbo_intlv_addr_seq_if
    import turbo_intlv_pkg::*;
#(
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int D_WIDTH = D_WIDTH_DEF
);
    logic               out_valid;
    logic               out_ready;
    logic [A_WIDTH-1:0] out_idx;
    logic [D_WIDTH-1:0] out_addr;
    logic               out_last;

    modport master (
        output out_valid,
        output out_idx,
        output out_addr,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_addr,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/turbo_intlv_addr_seq.sv
// Walks a permutation table in RAM and streams (index, interleaved address) pairs.
// Latency: first pair valid 2 cycles after start; 1 pair/cycle when unstalled.
// Backpressure: RAM reads pause while a pair is held, so RAM rdata carries the stall.
module turbo_intlv_addr_seq
    import turbo_intlv_pkg::*;
#(
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int D_WIDTH = D_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start,
    input  logic [A_WIDTH-1:0]      base,
    input  logic [A_WIDTH-1:0]      len,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    ram_ren,
    output logic [A_WIDTH-1:0]      ram_raddr,
    input  logic [D_WIDTH-1:0]      ram_rdata,
    turbo_intlv_addr_seq_if.master  ob
);

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] base_q, len_q, rd_cnt_q, idx_q;
    logic               vld_q, last_q, err_q, zero_done_q;
    logic               accept, start_ok;

    assign accept   = vld_q && ob.out_ready;
    assign start_ok = (state_q == IDLE) && start && (len != '0);

    assign ram_ren   = (state_q == RUN) && (rd_cnt_q < len_q) && (!vld_q || ob.out_ready);
    assign ram_raddr = base_q + rd_cnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (accept && last_q) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            idx_q       <= '0;
            vld_q       <= 1'b0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            // An empty block finishes without ever leaving IDLE
            zero_done_q <= (state_q == IDLE) && start && (len == '0);

            if (start_ok) begin
                base_q   <= base;
                len_q    <= len;
                rd_cnt_q <= '0;
                err_q    <= 1'b0;
            end else begin
                if (ram_ren)
                    rd_cnt_q <= rd_cnt_q + 1'b1;
                if (accept && (ram_rdata >= len_q))
                    err_q <= 1'b1;
            end

            if (ram_ren)
                vld_q <= 1'b1;
            else if (accept)
                vld_q <= 1'b0;

            // Index and last flag travel alongside the RAM read so they line up with rdata
            if (ram_ren) begin
                idx_q  <= rd_cnt_q;
                last_q <= (rd_cnt_q == len_q - 1'b1);
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == FIN) || zero_done_q;
    assign err  = err_q;

    assign ob.out_valid = vld_q;
    assign ob.out_idx   = idx_q;
    assign ob.out_addr  = ram_rdata;
    assign ob.out_last  = last_q;

endmodule

// File: tb/tb_turbo_intlv_addr_seq.sv
// Scoreboard bench for the interleaver address sequencer with a behavioural 1-cycle RAM.
module tb_turbo_intlv_addr_seq;
    import turbo_intlv_pkg::*;

    localparam int AW = 13;
    localparam int DW = 13;

    typedef struct packed {
        logic          last;
        logic [AW-1:0] idx;
        logic [DW-1:0] addr;
    } pair_t;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW-1:0] len = '0;
    logic          busy, done, err, ram_ren;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata = '0;

    turbo_intlv_addr_seq_if #(.A_WIDTH(AW), .D_WIDTH(DW)) ob ();

    turbo_intlv_addr_seq #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .base      (base),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ram_ren   (ram_ren),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .ob        (ob)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [8192];
    always @(posedge clk) if (ram_ren) ram_rdata <= mem[ram_raddr];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    pair_t         exp_q[$];
    pair_t         e;
    logic [AW-1:0] raddr_log[$];
    int            cyc = 0, first_acc = 0, last_acc = 0, acc_cnt = 0, done_cnt = 0;
    logic          prev_stall = 0, prev_last_acc = 0, chk_err_next = 0, exp_err_m = 0;
    logic          rdy_mode = 0, log_raddr = 0;
    logic [AW-1:0] stall_idx, cur_len = '0;
    logic [DW-1:0] stall_addr;
    int            rcnt = 0;

    // Ready pattern: always 1, or 1,0,0 repeating
    initial begin
        ob.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ob.out_ready = rdy_mode ? (rcnt % 3 == 0) : 1'b1;
            rcnt++;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (!n_rst) begin
            prev_stall    = 0;
            prev_last_acc = 0;
            chk_err_next  = 0;
        end else begin
            if (prev_last_acc) chk("done_after_last", {30'd0, busy, done}, 32'd1);
            if (chk_err_next)  chk("err_sticky", {31'd0, err}, {31'd0, exp_err_m});
            if (done) done_cnt++;
            if (ram_ren && log_raddr) raddr_log.push_back(ram_raddr);
            if (prev_stall)
                chk("stall_hold", {6'd0, ob.out_idx, ob.out_addr}, {6'd0, stall_idx, stall_addr});
            prev_stall    = 0;
            prev_last_acc = 0;
            chk_err_next  = 0;
            if (ob.out_valid && !ob.out_ready) begin
                chk("stall_ren", {31'd0, ram_ren}, 32'd0);
                prev_stall = 1;
                stall_idx  = ob.out_idx;
                stall_addr = ob.out_addr;
            end
            if (ob.out_valid && ob.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_pair", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pair", {5'd0, ob.out_last, ob.out_idx, ob.out_addr}, {5'd0, e});
                    prev_last_acc = e.last;
                end
                if (acc_cnt == 0) first_acc = cyc;
                last_acc = cyc;
                acc_cnt++;
                if (ob.out_addr >= cur_len) exp_err_m = 1;
                chk_err_next = 1;
            end
        end
    end

    task automatic start_pulse(input logic [AW-1:0] b, input logic [AW-1:0] l);
        @(posedge clk);
        #1;
        start = 1'b1;
        base  = b;
        len   = l;
        if (l != '0) begin
            cur_len   = l;
            exp_err_m = 0;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_block(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic poke);
        logic [AW-1:0] a;
        logic          exp_err;
        int            c;
        exp_err = 0;
        for (int i = 0; i < int'(l); i++) begin
            a = b + AW'(i);
            exp_q.push_back({(i == int'(l) - 1), AW'(i), mem[a]});
            if (mem[a] >= l) exp_err = 1;
        end
        acc_cnt = 0;
        start_pulse(b, l);
        if (poke) begin
            repeat (3) @(posedge clk);
            #1;
            start = 1'b1; base = 13'd200; len = 13'd3;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        c = 0;
        while (!done && c < 400) begin
            @(negedge clk);
            c++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("busy_in_fin", {31'd0, busy}, 32'd0);
        if (poke) begin
            start = 1'b1; base = 13'd300; len = 13'd5;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            chk("fin_start_ign", {29'd0, busy, ob.out_valid, ram_ren}, 32'd0);
        end
        repeat (2) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("acc_count", acc_cnt, {19'd0, l});
        chk("err_end", {31'd0, err}, {31'd0, exp_err});
    endtask

    initial begin
        int            c;
        int            dc;
        logic [AW-1:0] wrap_exp [4];
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        for (int i = 0; i < 8; i++) mem[i] = DW'((5 * i) % 8);
        mem[100] = 13'd3; mem[101] = 13'd9; mem[102] = 13'd1; mem[103] = 13'd0;
        mem[8190] = 13'd2; mem[8191] = 13'd3;

        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {busy, done, err, ram_ren, ram_raddr, ob.out_valid, ob.out_idx, ob.out_last}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // Full-rate permutation walk
        rdy_mode = 0;
        run_block(13'd0, 13'd8, 1'b0);
        chk("consecutive", last_acc - first_acc, 32'd7);

        // Stalled walk, with starts poked while busy and during FIN
        rdy_mode = 1;
        run_block(13'd0, 13'd8, 1'b1);
        rdy_mode = 0;

        // Out-of-range data raises err, next clean block clears it
        run_block(13'd100, 13'd4, 1'b0);
        run_block(13'd0, 13'd8, 1'b0);

        // Empty block
        start_pulse(13'd0, 13'd0);
        chk("zero_done", {29'd0, done, busy, ram_ren}, 32'd4);
        @(posedge clk);
        #1;
        chk("zero_done_pulse", {29'd0, done, busy, ram_ren}, 32'd0);

        // Reset in the middle of a block
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), AW'(i), mem[i]});
        acc_cnt = 0;
        start_pulse(13'd0, 13'd8);
        c = 0;
        while (acc_cnt < 3 && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("rst_pairs_seen", {31'd0, (acc_cnt >= 3)}, 32'd1);
        n_rst = 1'b0;
        dc = done_cnt;
        #1;
        chk("midblock_reset", {busy, done, err, ram_ren, ram_raddr, ob.out_valid, ob.out_idx, ob.out_last}, 32'd0);
        exp_q.delete();
        exp_err_m = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_done_on_reset", done_cnt, dc);
        run_block(13'd0, 13'd8, 1'b0);

        // Address wrap at the top of the RAM
        wrap_exp[0] = 13'd8190; wrap_exp[1] = 13'd8191; wrap_exp[2] = 13'd0; wrap_exp[3] = 13'd1;
        raddr_log.delete();
        log_raddr = 1;
        run_block(13'd8190, 13'd4, 1'b0);
        log_raddr = 0;
        chk("wrap_count", raddr_log.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < raddr_log.size()) chk("wrap_raddr", {19'd0, raddr_log[i]}, {19'd0, wrap_exp[i]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
